// File: rtl/ins_prefetch_queue.sv
// Instruction prefetch queue: streams bytes from a 1-cycle synchronous ROM into a
// circular buffer and presents a 3-byte decode window at pc_out.
module ins_prefetch_queue #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned AW    = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    output logic                       rom_en,
    output logic [AW-1:0]              rom_addr,
    input  logic [7:0]                 rom_data,
    input  logic                       redirect,
    input  logic [AW-1:0]              redirect_pc,
    input  logic                       adv,
    input  logic [1:0]                 adv_cnt,
    output logic [7:0]                 ins0,
    output logic [7:0]                 ins1,
    output logic [7:0]                 ins2,
    output logic [AW-1:0]              pc_out,
    output logic                       win_valid,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [7:0]    mem [DEPTH];
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [AW-1:0] fetch_pc;
    logic          inflight;
    logic          push;
    logic          pop;

    // Issue only while the queue plus the outstanding read still leaves a free slot.
    always_comb begin
        rom_en   = !rst && !redirect &&
                   ((CW+1)'(count) + (CW+1)'(inflight) < (CW+1)'(DEPTH));
        rom_addr = fetch_pc;
        push     = inflight;
        pop      = adv && (adv_cnt != 2'd0) && (CW'(adv_cnt) <= count);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            fetch_pc <= '0;
            pc_out   <= '0;
            inflight <= 1'b0;
        end else if (redirect) begin
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            fetch_pc <= redirect_pc;
            pc_out   <= redirect_pc;
            inflight <= 1'b0;
        end else begin
            inflight <= rom_en;
            if (rom_en) begin
                fetch_pc <= fetch_pc + AW'(1);
            end
            if (push) begin
                tail <= tail + PW'(1);
            end
            if (pop) begin
                head   <= head + PW'(adv_cnt);
                pc_out <= pc_out + AW'(adv_cnt);
            end
            count <= count + CW'(push) - (pop ? CW'(adv_cnt) : CW'(0));
        end
    end

    // Storage array carries no reset; occupancy is tracked by count alone.
    always_ff @(posedge clk) begin
        if (!rst && !redirect && push) begin
            mem[tail] <= rom_data;
        end
    end

    always_comb begin
        ins0      = (count > CW'(0)) ? mem[head]             : 8'h00;
        ins1      = (count > CW'(1)) ? mem[head + PW'(1)]    : 8'h00;
        ins2      = (count > CW'(2)) ? mem[head + PW'(2)]    : 8'h00;
        win_valid = (count >= CW'(3));
    end

endmodule

// File: tb/tb_ins_prefetch_queue.sv
// Self-checking bench for ins_prefetch_queue: directed table, hand sequences for
// redirect/wrap/reset corners, then random traffic against a queue-based model.
module tb_ins_prefetch_queue;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        rom_en;
    logic [15:0] rom_addr;
    logic [7:0]  rom_data;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic        adv;
    logic [1:0]  adv_cnt;
    logic [7:0]  ins0, ins1, ins2;
    logic [15:0] pc_out;
    logic        win_valid;
    logic [3:0]  count;

    int n_chk  = 0;
    int n_fail = 0;
    int n_proto = 0;

    ins_prefetch_queue #(.DEPTH(DEPTH), .AW(16)) dut (
        .clk(clk), .rst(rst), .rom_en(rom_en), .rom_addr(rom_addr), .rom_data(rom_data),
        .redirect(redirect), .redirect_pc(redirect_pc), .adv(adv), .adv_cnt(adv_cnt),
        .ins0(ins0), .ins1(ins1), .ins2(ins2), .pc_out(pc_out),
        .win_valid(win_valid), .count(count)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] rom_byte(input logic [15:0] a);
        return a[7:0] ^ a[15:8];
    endfunction

    // Synchronous ROM, one cycle of read latency.
    always @(posedge clk) begin
        if (rom_en) rom_data <= rom_byte(rom_addr);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the queue contents as a plain byte queue.
    logic [7:0]  mq[$];
    logic [15:0] m_pc, m_fpc, m_iaddr;
    bit          m_infl = 1'b0;
    bit          m_ok   = 1'b0;

    function automatic bit model_en();
        return !rst && !redirect && (mq.size() + int'(m_infl) < DEPTH);
    endfunction

    task automatic model_check();
        bit en;
        if (!m_ok) return;
        en = model_en();
        chk("m_count", 32'(count), 32'(mq.size()));
        chk("m_pc_out", 32'(pc_out), 32'(m_pc));
        chk("m_ins0", 32'(ins0), (mq.size() > 0) ? 32'(mq[0]) : 32'h0);
        chk("m_ins1", 32'(ins1), (mq.size() > 1) ? 32'(mq[1]) : 32'h0);
        chk("m_ins2", 32'(ins2), (mq.size() > 2) ? 32'(mq[2]) : 32'h0);
        chk("m_win_valid", 32'(win_valid), 32'(mq.size() >= 3));
        chk("m_rom_en", 32'(rom_en), 32'(en));
        if (en) chk("m_rom_addr", 32'(rom_addr), 32'(m_fpc));
    endtask

    task automatic model_update();
        bit en;
        en = model_en();
        if (rst) begin
            mq.delete();
            m_pc = 16'h0; m_fpc = 16'h0; m_infl = 1'b0; m_ok = 1'b1;
        end else if (redirect) begin
            mq.delete();
            m_pc = redirect_pc; m_fpc = redirect_pc; m_infl = 1'b0;
        end else begin
            if (adv && adv_cnt != 2'd0) begin
                if (int'(adv_cnt) <= mq.size()) begin
                    repeat (int'(adv_cnt)) void'(mq.pop_front());
                    m_pc = m_pc + 16'(adv_cnt);
                end else begin
                    n_proto++;
                end
            end
            if (m_infl) mq.push_back(rom_byte(m_iaddr));
            m_infl = en;
            if (en) begin
                m_iaddr = m_fpc;
                m_fpc   = m_fpc + 16'h1;
            end
        end
    endtask

    task automatic mid();
        @(negedge clk);
        model_check();
    endtask

    task automatic fin();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic idle();
        rst = 1'b0; redirect = 1'b0; adv = 1'b0; adv_cnt = 2'd0;
    endtask

    typedef struct {
        bit          adv;
        logic [1:0]  cnt;
        int          cnt_e;
        logic [15:0] pc_e;
        logic [7:0]  i0, i1, i2;
        bit          win_e;
        bit          en_e;
        logic [15:0] addr_e;
    } vec_t;

    vec_t vecs[16];

    initial begin
        // Fill from reset, then drain 3 per cycle until the over-count advance is ignored.
        vecs[0]  = '{0, 2'd0, 0, 16'd0, 8'h00, 8'h00, 8'h00, 0, 1, 16'd0};
        vecs[1]  = '{0, 2'd0, 0, 16'd0, 8'h00, 8'h00, 8'h00, 0, 1, 16'd1};
        vecs[2]  = '{0, 2'd0, 1, 16'd0, 8'h00, 8'h00, 8'h00, 0, 1, 16'd2};
        vecs[3]  = '{0, 2'd0, 2, 16'd0, 8'h00, 8'h01, 8'h00, 0, 1, 16'd3};
        vecs[4]  = '{0, 2'd0, 3, 16'd0, 8'h00, 8'h01, 8'h02, 1, 1, 16'd4};
        vecs[5]  = '{0, 2'd0, 4, 16'd0, 8'h00, 8'h01, 8'h02, 1, 1, 16'd5};
        vecs[6]  = '{0, 2'd0, 5, 16'd0, 8'h00, 8'h01, 8'h02, 1, 1, 16'd6};
        vecs[7]  = '{0, 2'd0, 6, 16'd0, 8'h00, 8'h01, 8'h02, 1, 1, 16'd7};
        vecs[8]  = '{0, 2'd0, 7, 16'd0, 8'h00, 8'h01, 8'h02, 1, 0, 16'd0};
        vecs[9]  = '{0, 2'd0, 8, 16'd0, 8'h00, 8'h01, 8'h02, 1, 0, 16'd0};
        vecs[10] = '{0, 2'd0, 8, 16'd0, 8'h00, 8'h01, 8'h02, 1, 0, 16'd0};
        vecs[11] = '{1, 2'd3, 8, 16'd0, 8'h00, 8'h01, 8'h02, 1, 0, 16'd0};
        vecs[12] = '{1, 2'd3, 5, 16'd3, 8'h03, 8'h04, 8'h05, 1, 1, 16'd8};
        vecs[13] = '{1, 2'd3, 2, 16'd6, 8'h06, 8'h07, 8'h00, 0, 1, 16'd9};
        vecs[14] = '{1, 2'd1, 3, 16'd6, 8'h06, 8'h07, 8'h08, 1, 1, 16'd10};
        vecs[15] = '{0, 2'd0, 3, 16'd7, 8'h07, 8'h08, 8'h09, 1, 1, 16'd11};

        idle();
        redirect_pc = 16'h0;
        rst = 1'b1;
        mid();
        chk("rst_rom_en", 32'(rom_en), 32'h0);
        fin();

        for (int i = 0; i < 16; i++) begin
            idle();
            adv = vecs[i].adv; adv_cnt = vecs[i].cnt;
            mid();
            chk($sformatf("tbl%0d_count", i), 32'(count), 32'(vecs[i].cnt_e));
            chk($sformatf("tbl%0d_pc", i), 32'(pc_out), 32'(vecs[i].pc_e));
            chk($sformatf("tbl%0d_ins0", i), 32'(ins0), 32'(vecs[i].i0));
            chk($sformatf("tbl%0d_ins1", i), 32'(ins1), 32'(vecs[i].i1));
            chk($sformatf("tbl%0d_ins2", i), 32'(ins2), 32'(vecs[i].i2));
            chk($sformatf("tbl%0d_win", i), 32'(win_valid), 32'(vecs[i].win_e));
            chk($sformatf("tbl%0d_rom_en", i), 32'(rom_en), 32'(vecs[i].en_e));
            if (vecs[i].en_e) chk($sformatf("tbl%0d_addr", i), 32'(rom_addr), 32'(vecs[i].addr_e));
            fin();
        end

        // Redirect with a byte in flight: stale byte dropped, window refills from 0100.
        idle();
        redirect = 1'b1; redirect_pc = 16'h0100;
        mid();
        chk("redir_t0_rom_en", 32'(rom_en), 32'h0);
        fin();
        for (int k = 1; k <= 5; k++) begin
            idle();
            mid();
            if (k == 1) begin
                chk("redir_t1_rom_en", 32'(rom_en), 32'h1);
                chk("redir_t1_addr", 32'(rom_addr), 32'h0100);
                chk("redir_t1_count", 32'(count), 32'h0);
                chk("redir_t1_pc", 32'(pc_out), 32'h0100);
            end
            if (k == 2) chk("redir_t2_count", 32'(count), 32'h0);
            if (k == 3) chk("redir_t3_count", 32'(count), 32'h1);
            if (k == 4) chk("redir_t4_win", 32'(win_valid), 32'h0);
            if (k == 5) begin
                chk("redir_t5_win", 32'(win_valid), 32'h1);
                chk("redir_t5_ins0", 32'(ins0), 32'(rom_byte(16'h0100)));
            end
            fin();
        end

        // Fetch and pc_out wrap across FFFF.
        idle();
        redirect = 1'b1; redirect_pc = 16'hFFFE;
        mid();
        fin();
        for (int k = 1; k <= 5; k++) begin
            idle();
            if (k == 4) begin adv = 1'b1; adv_cnt = 2'd2; end
            mid();
            if (k == 1) chk("wrap_addr0", 32'(rom_addr), 32'hFFFE);
            if (k == 2) chk("wrap_addr1", 32'(rom_addr), 32'hFFFF);
            if (k == 3) chk("wrap_addr2", 32'(rom_addr), 32'h0000);
            if (k == 4) chk("wrap_pc_before", 32'(pc_out), 32'hFFFE);
            if (k == 5) chk("wrap_pc_after", 32'(pc_out), 32'h0000);
            fin();
        end

        // Reset mid-stream overrides a simultaneous redirect.
        for (int k = 0; k < 3; k++) begin idle(); mid(); fin(); end
        idle();
        rst = 1'b1; redirect = 1'b1; redirect_pc = 16'h1234;
        mid();
        chk("rst_redir_rom_en", 32'(rom_en), 32'h0);
        fin();
        idle();
        mid();
        chk("rst_redir_count", 32'(count), 32'h0);
        chk("rst_redir_pc", 32'(pc_out), 32'h0);
        chk("rst_redir_addr", 32'(rom_addr), 32'h0);
        chk("rst_redir_win", 32'(win_valid), 32'h0);
        chk("rst_redir_ins0", 32'(ins0), 32'h0);
        fin();

        // Random traffic, including over-count advances that must be ignored.
        for (int c = 0; c < 3000; c++) begin
            idle();
            rst         = ($urandom_range(0, 199) == 0);
            redirect    = ($urandom_range(0, 24) == 0);
            redirect_pc = 16'($urandom);
            adv         = ($urandom_range(0, 1) == 1);
            adv_cnt     = 2'($urandom_range(0, 3));
            mid();
            fin();
        end

        $display("note: %0d over-count advances were issued and expected to be ignored", n_proto);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
